// File: rtl/bram_stream_accessor.sv
`default_nettype none
//============================================================================
// Module   : bram_stream_accessor
// Streams N words from BRAM0 through a per-lane operation into BRAM1,
// one word per clock with a fixed two-clock read-to-write latency.
// Revision : 1.0
//============================================================================
module bram_stream_accessor #(
   parameter  int NUM_LANES = 4,
   parameter  int IN_W      = 8,
   parameter  int OUT_W     = 16,
   parameter  int AWIDTH    = 8,
   parameter  int CNT_BIT   = AWIDTH + 1,
   localparam int DWIDTH_1  = NUM_LANES * IN_W,
   localparam int DWIDTH_2  = NUM_LANES * OUT_W
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start_run_i,
   input  logic [CNT_BIT-1:0]  run_count_i,
   input  logic [1:0]          mode_i,
   input  logic [IN_W-1:0]     coef_i,
   input  logic [AWIDTH-1:0]   base_b0_i,
   input  logic [AWIDTH-1:0]   base_b1_i,
   output logic                idle_o,
   output logic                read_o,
   output logic                write_o,
   output logic                done_o,
   output logic [AWIDTH-1:0]   addr_b0_o,
   output logic                ce_b0_o,
   output logic                we_b0_o,
   output logic [DWIDTH_1-1:0] d_b0_o,
   input  logic [DWIDTH_1-1:0] q_b0_i,
   output logic [AWIDTH-1:0]   addr_b1_o,
   output logic                ce_b1_o,
   output logic                we_b1_o,
   output logic [DWIDTH_2-1:0] d_b1_o,
   input  logic [DWIDTH_2-1:0] q_b1_i
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RUN    = 3'd1;
   localparam logic [2:0] S_DRAIN1 = 3'd2;
   localparam logic [2:0] S_DRAIN2 = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;
   localparam int         SUM_W    = OUT_W + 1;

   logic [2:0]          r_state;
   logic [CNT_BIT-1:0]  r_remaining;
   logic [1:0]          r_mode;
   logic [IN_W-1:0]     r_coef;
   logic [AWIDTH-1:0]   r_addr_b0;
   logic [AWIDTH-1:0]   r_addr_b1;
   logic                r_v1;
   logic                r_v2;
   logic [DWIDTH_2-1:0] r_result;
   logic [DWIDTH_2-1:0] r_acc;

   logic                w_accept;
   logic                w_run;
   logic                w_last_rd;
   logic                w_nonzero;
   logic [DWIDTH_2-1:0] w_res_next;
   logic [DWIDTH_2-1:0] w_acc_next;
   logic                w_unused;

   assign w_accept  = (r_state == S_IDLE) && start_run_i;
   assign w_nonzero = (run_count_i != '0);
   assign w_run     = (r_state == S_RUN);
   assign w_last_rd = w_run && (r_remaining == CNT_BIT'(1));
   assign w_unused  = ^q_b1_i;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_remaining <= '0;
         r_mode      <= '0;
         r_coef      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_run_i) begin
                  r_state     <= w_nonzero ? S_RUN : S_DONE;
                  r_remaining <= run_count_i;
                  r_mode      <= mode_i;
                  r_coef      <= coef_i;
               end
            end
            S_RUN: begin
               r_remaining <= r_remaining - CNT_BIT'(1);
               if (w_last_rd) r_state <= S_DRAIN1;
            end
            S_DRAIN1: r_state <= S_DRAIN2;
            S_DRAIN2: r_state <= S_DONE;
            S_DONE:   r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   // Addresses load only for real runs so they hold their last value otherwise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr_b0 <= '0;
         r_addr_b1 <= '0;
      end else if (w_accept && w_nonzero) begin
         r_addr_b0 <= base_b0_i;
         r_addr_b1 <= base_b1_i;
      end else begin
         if (w_run && !w_last_rd) r_addr_b0 <= r_addr_b0 + AWIDTH'(1);
         if (r_v2 && r_v1)        r_addr_b1 <= r_addr_b1 + AWIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_v1     <= 1'b0;
         r_v2     <= 1'b0;
         r_result <= '0;
         r_acc    <= '0;
      end else begin
         r_v1 <= w_run;
         r_v2 <= r_v1;
         if (r_v1) r_result <= w_res_next;
         if (w_accept)                      r_acc <= '0;
         else if (r_v1 && (r_mode == 2'd3)) r_acc <= w_acc_next;
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      logic [IN_W-1:0]   w_x;
      logic [2*IN_W-1:0] w_sq;
      logic [2*IN_W-1:0] w_mul;
      logic [SUM_W-1:0]  w_sum;
      logic [OUT_W-1:0]  w_acc_lane;
      logic [OUT_W-1:0]  w_lane;

      assign w_x   = q_b0_i[i*IN_W +: IN_W];
      assign w_sq  = {{IN_W{1'b0}}, w_x} * {{IN_W{1'b0}}, w_x};
      assign w_mul = {{IN_W{1'b0}}, w_x} * {{IN_W{1'b0}}, r_coef};
      assign w_sum = {1'b0, r_acc[i*OUT_W +: OUT_W]} + SUM_W'(w_mul);
      // Carry out of the OUT_W-bit sum means the running total saturates.
      assign w_acc_lane = w_sum[OUT_W] ? {OUT_W{1'b1}} : w_sum[OUT_W-1:0];

      always_comb begin
         w_lane = '0;
         case (r_mode)
            2'd0:    w_lane = OUT_W'(w_x);
            2'd1:    w_lane = OUT_W'(w_sq);
            2'd2:    w_lane = OUT_W'(w_mul);
            default: w_lane = w_acc_lane;
         endcase
      end

      assign w_res_next[i*OUT_W +: OUT_W] = w_lane;
      assign w_acc_next[i*OUT_W +: OUT_W] = w_acc_lane;
   end

   assign idle_o    = (r_state == S_IDLE);
   assign read_o    = w_run;
   assign done_o    = (r_state == S_DONE);
   assign write_o   = r_v2;
   assign ce_b0_o   = w_run;
   assign we_b0_o   = 1'b0;
   assign d_b0_o    = '0;
   assign addr_b0_o = r_addr_b0;
   assign ce_b1_o   = r_v2;
   assign we_b1_o   = r_v2;
   assign addr_b1_o = r_addr_b1;
   assign d_b1_o    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_accessor.sv
`default_nettype none
//============================================================================
// Module   : tb_bram_stream_accessor
// Self-checking bench: BRAM models, write monitors and a lane-arithmetic model.
// Revision : 1.0
//============================================================================
module tb_bram_stream_accessor;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   // instance A: default parameters
   logic        start_a = 1'b0;
   logic [8:0]  cnt_a = '0;
   logic [1:0]  mode_a = '0;
   logic [7:0]  coef_a = '0, b0_a = '0, b1_a = '0;
   logic        idle_a, read_a, write_a, done_a, ce_b0_a, we_b0_a, ce_b1_a, we_b1_a;
   logic [7:0]  addr_b0_a, addr_b1_a;
   logic [31:0] d_b0_a, q_b0_a;
   logic [63:0] d_b1_a, q_b1_a;

   // instance B: 8 lanes of 4 -> 8 bits
   logic        start_b = 1'b0;
   logic [8:0]  cnt_b = '0;
   logic [1:0]  mode_b = '0;
   logic [3:0]  coef_b = '0;
   logic [7:0]  b0_b = '0, b1_b = '0;
   logic        idle_b, read_b, write_b, done_b, ce_b0_b, we_b0_b, ce_b1_b, we_b1_b;
   logic [7:0]  addr_b0_b, addr_b1_b;
   logic [31:0] d_b0_b, q_b0_b;
   logic [63:0] d_b1_b, q_b1_b;

   bram_stream_accessor dut_a (
      .clk(clk), .reset_n(reset_n), .start_run_i(start_a), .run_count_i(cnt_a),
      .mode_i(mode_a), .coef_i(coef_a), .base_b0_i(b0_a), .base_b1_i(b1_a),
      .idle_o(idle_a), .read_o(read_a), .write_o(write_a), .done_o(done_a),
      .addr_b0_o(addr_b0_a), .ce_b0_o(ce_b0_a), .we_b0_o(we_b0_a), .d_b0_o(d_b0_a),
      .q_b0_i(q_b0_a), .addr_b1_o(addr_b1_a), .ce_b1_o(ce_b1_a), .we_b1_o(we_b1_a),
      .d_b1_o(d_b1_a), .q_b1_i(q_b1_a)
   );

   bram_stream_accessor #(.NUM_LANES(8), .IN_W(4), .OUT_W(8), .AWIDTH(8)) dut_b (
      .clk(clk), .reset_n(reset_n), .start_run_i(start_b), .run_count_i(cnt_b),
      .mode_i(mode_b), .coef_i(coef_b), .base_b0_i(b0_b), .base_b1_i(b1_b),
      .idle_o(idle_b), .read_o(read_b), .write_o(write_b), .done_o(done_b),
      .addr_b0_o(addr_b0_b), .ce_b0_o(ce_b0_b), .we_b0_o(we_b0_b), .d_b0_o(d_b0_b),
      .q_b0_i(q_b0_b), .addr_b1_o(addr_b1_b), .ce_b1_o(ce_b1_b), .we_b1_o(we_b1_b),
      .d_b1_o(d_b1_b), .q_b1_i(q_b1_b)
   );

   logic [31:0] mem0a [256];
   logic [31:0] mem0b [256];
   logic [63:0] mem1a [256];
   logic [63:0] mem1b [256];

   always @(posedge clk) begin
      if (ce_b0_a) q_b0_a <= mem0a[addr_b0_a];
      if (ce_b1_a) q_b1_a <= mem1a[addr_b1_a];
      if (ce_b1_a && we_b1_a) mem1a[addr_b1_a] <= d_b1_a;
      if (ce_b0_b) q_b0_b <= mem0b[addr_b0_b];
      if (ce_b1_b) q_b1_b <= mem1b[addr_b1_b];
      if (ce_b1_b && we_b1_b) mem1b[addr_b1_b] <= d_b1_b;
   end

   logic [7:0]  raddr_a[$];
   logic [7:0]  waddr_a[$];
   logic [63:0] wdata_a[$];
   logic [7:0]  waddr_b[$];
   logic [63:0] wdata_b[$];
   logic [7:0]  exp_addr[$];
   logic [63:0] exp_data[$];

   always @(negedge clk) begin
      if (ce_b0_a) raddr_a.push_back(addr_b0_a);
      if (ce_b1_a && we_b1_a) begin
         waddr_a.push_back(addr_b1_a);
         wdata_a.push_back(d_b1_a);
      end
      if (ce_b1_b && we_b1_b) begin
         waddr_b.push_back(addr_b1_b);
         wdata_b.push_back(d_b1_b);
      end
   end

   int n_pass = 0;
   int n_total = 0;

   // Reference: each output lane computed directly from the arithmetic rules.
   function automatic void model_run(input int n, input int mode, input int coef,
                                     input int b0, input int b1, input int lanes,
                                     input int in_w, input int out_w, input bit use_b);
      longint acc[8];
      longint x, v, lmask, omax;
      logic [63:0] word;
      logic [31:0] src;
      exp_addr.delete();
      exp_data.delete();
      for (int i = 0; i < 8; i++) acc[i] = 0;
      lmask = (longint'(1) << in_w) - 1;
      omax  = (longint'(1) << out_w) - 1;
      for (int k = 0; k < n; k++) begin
         src  = use_b ? mem0b[(b0 + k) % 256] : mem0a[(b0 + k) % 256];
         word = '0;
         for (int i = 0; i < lanes; i++) begin
            x = (longint'(src) >> (i * in_w)) & lmask;
            case (mode)
               0: v = x;
               1: v = x * x;
               2: v = x * coef;
               default: begin
                  acc[i] = acc[i] + x * coef;
                  if (acc[i] > omax) acc[i] = omax;
                  v = acc[i];
               end
            endcase
            word = word | (64'(v) << (i * out_w));
         end
         exp_addr.push_back(8'((b1 + k) % 256));
         exp_data.push_back(word);
      end
   endfunction

   task automatic run_a(input int n, input int mode, input int coef, input int b0,
                        input int b1, output int lat, output bit tmo);
      int e;
      @(posedge clk); #1;
      raddr_a.delete(); waddr_a.delete(); wdata_a.delete();
      start_a = 1'b1; cnt_a = 9'(n); mode_a = 2'(mode); coef_a = 8'(coef);
      b0_a = 8'(b0); b1_a = 8'(b1);
      @(posedge clk); #1;
      start_a = 1'b0; cnt_a = 9'($urandom); mode_a = 2'($urandom);
      coef_a = 8'($urandom); b0_a = 8'($urandom); b1_a = 8'($urandom);
      e = 0;
      while (done_a !== 1'b1 && e < 600) begin
         @(posedge clk); #1;
         e++;
      end
      tmo = (done_a !== 1'b1);
      lat = e + 2;   // accept cycle through done cycle, inclusive
      @(posedge clk); #1;
   endtask

   task automatic run_b(input int n, input int mode, input int coef, input int b0,
                        input int b1, output int lat, output bit tmo);
      int e;
      @(posedge clk); #1;
      waddr_b.delete(); wdata_b.delete();
      start_b = 1'b1; cnt_b = 9'(n); mode_b = 2'(mode); coef_b = 4'(coef);
      b0_b = 8'(b0); b1_b = 8'(b1);
      @(posedge clk); #1;
      start_b = 1'b0;
      e = 0;
      while (done_b !== 1'b1 && e < 600) begin
         @(posedge clk); #1;
         e++;
      end
      tmo = (done_b !== 1'b1);
      lat = e + 2;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_total++;
      if ({idle_a, read_a, write_a, done_a, ce_b0_a, we_b0_a, ce_b1_a, we_b1_a} !== 8'b1000_0000) begin
         $display("FAIL reset_flags: got %b expected 10000000",
                  {idle_a, read_a, write_a, done_a, ce_b0_a, we_b0_a, ce_b1_a, we_b1_a});
      end else n_pass++;
      n_total++;
      if ({addr_b0_a, addr_b1_a, d_b0_a} !== '0) begin
         $display("FAIL reset_addr: got %h %h %h expected 0", addr_b0_a, addr_b1_a, d_b0_a);
      end else n_pass++;
      n_total++;
      if (d_b1_a !== 64'd0) $display("FAIL reset_d_b1: got %h expected 0", d_b1_a);
      else n_pass++;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      n_total++;
      if (idle_a !== 1'b1 || idle_b !== 1'b1)
         $display("FAIL reset_release_idle: got %b%b expected 11", idle_a, idle_b);
      else n_pass++;
   endtask

   task automatic test_square_full();
      int lat, bad;
      bit tmo;
      for (int i = 0; i < 256; i++) mem0a[i] = 32'h01030507;
      run_a(256, 1, 0, 0, 0, lat, tmo);
      n_total++;
      if (tmo || lat != 260) $display("FAIL t1_latency: got %0d (timeout %0d) expected 260", lat, tmo);
      else n_pass++;
      n_total++;
      if (waddr_a.size() != 256) $display("FAIL t1_write_count: got %0d expected 256", waddr_a.size());
      else n_pass++;
      bad = 0;
      for (int k = 0; k < waddr_a.size() && k < 256; k++)
         if (waddr_a[k] !== 8'(k) || wdata_a[k] !== 64'h0001_0009_0019_0031) bad++;
      n_total++;
      if (bad != 0) $display("FAIL t1_words: got %0d bad words expected 0", bad);
      else n_pass++;
      n_total++;
      if (idle_a !== 1'b1 || done_a !== 1'b0)
         $display("FAIL t1_done_pulse: got idle=%b done=%b expected idle=1 done=0", idle_a, done_a);
      else n_pass++;
   endtask

   task automatic test_wrap();
      int lat;
      bit tmo;
      int exp_rd[4] = '{254, 255, 0, 1};
      for (int i = 0; i < 256; i++) mem0a[i] = $urandom;
      run_a(4, 2, 3, 254, 253, lat, tmo);
      model_run(4, 2, 3, 254, 253, 4, 8, 16, 1'b0);
      n_total++;
      if (raddr_a.size() != 4 || waddr_a.size() != 4)
         $display("FAIL t2_counts: got rd=%0d wr=%0d expected 4/4", raddr_a.size(), waddr_a.size());
      else n_pass++;
      for (int k = 0; k < 4 && k < raddr_a.size() && k < waddr_a.size(); k++) begin
         n_total++;
         if (raddr_a[k] !== 8'(exp_rd[k]) || waddr_a[k] !== exp_addr[k] || wdata_a[k] !== exp_data[k])
            $display("FAIL t2_word[%0d]: got rd=%0d wr=%0d d=%h expected rd=%0d wr=%0d d=%h",
                     k, raddr_a[k], waddr_a[k], wdata_a[k], exp_rd[k], exp_addr[k], exp_data[k]);
         else n_pass++;
      end
      n_total++;
      if (tmo || lat != 8) $display("FAIL t2_latency: got %0d expected 8", lat);
      else n_pass++;
   endtask

   task automatic test_saturate();
      int lat;
      bit tmo;
      logic [63:0] want[3];
      want[0] = {4{16'd65025}};
      want[1] = {4{16'hFFFF}};
      want[2] = {4{16'hFFFF}};
      for (int i = 20; i < 23; i++) mem0a[i] = 32'hFFFF_FFFF;
      run_a(3, 3, 255, 20, 100, lat, tmo);
      n_total++;
      if (waddr_a.size() != 3) $display("FAIL t3_count: got %0d expected 3", waddr_a.size());
      else n_pass++;
      for (int k = 0; k < 3 && k < wdata_a.size(); k++) begin
         n_total++;
         if (wdata_a[k] !== want[k] || waddr_a[k] !== 8'(100 + k))
            $display("FAIL t3_sum[%0d]: got %h@%0d expected %h@%0d", k, wdata_a[k], waddr_a[k], want[k], 100 + k);
         else n_pass++;
      end
   endtask

   task automatic test_zero_count();
      int lat;
      bit tmo;
      run_a(0, 1, 5, 7, 9, lat, tmo);
      n_total++;
      if (tmo || lat != 2) $display("FAIL t4_zero_latency: got %0d expected 2", lat);
      else n_pass++;
      n_total++;
      if (raddr_a.size() != 0 || waddr_a.size() != 0)
         $display("FAIL t4_zero_access: got rd=%0d wr=%0d expected 0/0", raddr_a.size(), waddr_a.size());
      else n_pass++;
   endtask

   task automatic test_ignore_start();
      int e;
      @(posedge clk); #1;
      for (int i = 0; i < 256; i++) mem0a[i] = $urandom;
      raddr_a.delete(); waddr_a.delete(); wdata_a.delete();
      start_a = 1'b1; cnt_a = 9'd20; mode_a = 2'd0; coef_a = 8'd0; b0_a = 8'd10; b1_a = 8'd40;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      start_a = 1'b1; cnt_a = 9'd5; mode_a = 2'd1; b0_a = 8'd99; b1_a = 8'd0;
      @(posedge clk); #1;
      start_a = 1'b0;
      e = 0;
      while (done_a !== 1'b1 && e < 600) begin
         @(posedge clk); #1;
         e++;
      end
      n_total++;
      if (done_a !== 1'b1 || e != 16) $display("FAIL t4_ignore_latency: got %0d edges expected 16", e);
      else n_pass++;
      @(posedge clk); #1;
      model_run(20, 0, 0, 10, 40, 4, 8, 16, 1'b0);
      n_total++;
      if (waddr_a.size() != 20) $display("FAIL t4_ignore_count: got %0d expected 20", waddr_a.size());
      else n_pass++;
      for (int k = 0; k < 20 && k < waddr_a.size(); k++) begin
         n_total++;
         if (waddr_a[k] !== exp_addr[k] || wdata_a[k] !== exp_data[k])
            $display("FAIL t4_ignore_word[%0d]: got %h@%0d expected %h@%0d", k, wdata_a[k], waddr_a[k], exp_data[k], exp_addr[k]);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      int n, mode, coef, b0, b1, lat;
      bit tmo;
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < 256; i++) mem0a[i] = $urandom;
         n = $urandom_range(1, 40); mode = (it < 4) ? it : $urandom_range(0, 3);
         coef = $urandom_range(0, 255); b0 = $urandom_range(0, 255); b1 = $urandom_range(0, 255);
         run_a(n, mode, coef, b0, b1, lat, tmo);
         model_run(n, mode, coef, b0, b1, 4, 8, 16, 1'b0);
         n_total++;
         if (tmo || lat != n + 4 || waddr_a.size() != n || raddr_a.size() != n)
            $display("FAIL rand%0d_shape: got lat=%0d wr=%0d rd=%0d expected lat=%0d count=%0d",
                     it, lat, waddr_a.size(), raddr_a.size(), n + 4, n);
         else n_pass++;
         for (int k = 0; k < n && k < waddr_a.size(); k++) begin
            n_total++;
            if (waddr_a[k] !== exp_addr[k] || wdata_a[k] !== exp_data[k])
               $display("FAIL rand%0d_word[%0d] mode%0d: got %h@%0d expected %h@%0d",
                        it, k, mode, wdata_a[k], waddr_a[k], exp_data[k], exp_addr[k]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_abort();
      int e;
      @(posedge clk); #1;
      for (int i = 0; i < 256; i++) mem0a[i] = $urandom;
      raddr_a.delete(); waddr_a.delete(); wdata_a.delete();
      start_a = 1'b1; cnt_a = 9'd100; mode_a = 2'd2; coef_a = 8'd7; b0_a = 8'd0; b1_a = 8'd0;
      @(posedge clk); #1;
      start_a = 1'b0;
      e = 0;
      while (waddr_a.size() < 10 && e < 200) begin
         @(negedge clk); #1;
         e++;
      end
      n_total++;
      if (waddr_a.size() != 10) $display("FAIL t5_reach_10: got %0d writes expected 10", waddr_a.size());
      else n_pass++;
      reset_n = 1'b0;
      #1;
      n_total++;
      if ({idle_a, read_a, write_a, done_a, ce_b0_a, ce_b1_a, we_b1_a} !== 7'b1000000 || d_b1_a !== 64'd0)
         $display("FAIL t5_async_outputs: got %b d=%h expected 1000000 d=0",
                  {idle_a, read_a, write_a, done_a, ce_b0_a, ce_b1_a, we_b1_a}, d_b1_a);
      else n_pass++;
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      n_total++;
      if (waddr_a.size() != 10 || idle_a !== 1'b1)
         $display("FAIL t5_write_total: got %0d idle=%b expected 10 idle=1", waddr_a.size(), idle_a);
      else n_pass++;
   endtask

   task automatic test_wide_lanes();
      int lat, n, b0, b1, coef, mode;
      bit tmo;
      for (int it = 0; it < 2; it++) begin
         for (int i = 0; i < 256; i++) mem0b[i] = $urandom;
         n = 16; mode = (it == 0) ? 0 : 3; coef = $urandom_range(8, 15);
         b0 = $urandom_range(0, 255); b1 = $urandom_range(0, 255);
         run_b(n, mode, coef, b0, b1, lat, tmo);
         model_run(n, mode, coef, b0, b1, 8, 4, 8, 1'b1);
         n_total++;
         if (tmo || lat != n + 4 || waddr_b.size() != n)
            $display("FAIL t6_shape%0d: got lat=%0d wr=%0d expected lat=%0d wr=%0d", it, lat, waddr_b.size(), n + 4, n);
         else n_pass++;
         for (int k = 0; k < n && k < waddr_b.size(); k++) begin
            n_total++;
            if (waddr_b[k] !== exp_addr[k] || wdata_b[k] !== exp_data[k])
               $display("FAIL t6_word%0d[%0d]: got %h@%0d expected %h@%0d",
                        it, k, wdata_b[k], waddr_b[k], exp_data[k], exp_addr[k]);
            else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_square_full();
      test_wrap();
      test_saturate();
      test_zero_count();
      test_ignore_start();
      test_random();
      test_abort();
      test_wide_lanes();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
